// File: rtl/led_pattern_ctrl_pkg.sv
// Shared encodings for the 5-LED pattern sequencer: modes, FSM states, helpers.
package led_pattern_ctrl_pkg;

  localparam int NUM_LEDS = 5;

  // Host-visible mode encodings.
  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_CHASE  = 2'd3;

  // FSM state encodings (chase is split into its two sweep directions).
  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_STATIC = 3'd1;
  localparam logic [2:0] S_BLINK  = 3'd2;
  localparam logic [2:0] S_UP     = 3'd3;
  localparam logic [2:0] S_DOWN   = 3'd4;

  // Every mode enters its sequence at a fixed state; chase always starts sweeping up.
  function automatic logic [2:0] mode_entry_state(input logic [1:0] m);
    case (m)
      MODE_STATIC: return S_STATIC;
      MODE_BLINK:  return S_BLINK;
      MODE_CHASE:  return S_UP;
      default:     return S_OFF;
    endcase
  endfunction

  // One-hot LED vector for a chase position (0..4).
  function automatic logic [NUM_LEDS-1:0] pos_onehot(input logic [2:0] p);
    return 5'b00001 << p;
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Host-side bundle of the LED sequencer: config write, step tick, LED drives, debug view.
// Handshake: mode_we is a single-cycle valid with an implicit ready that is always 1;
// every strobed cycle is a committed write, there is no back-pressure and no hold.
interface led_pattern_ctrl_if;
  import led_pattern_ctrl_pkg::*;

  logic [1:0]          mode;
  logic [NUM_LEDS-1:0] pattern;
  logic                mode_we;
  logic                tick;
  logic                LED0;
  logic                LED1;
  logic                LED2;
  logic                LED3;
  logic                LED4;
  logic [2:0]          dbg_state;
  logic [1:0]          dbg_mode;

  modport master (
    output mode, pattern, mode_we,
    input  tick, LED0, LED1, LED2, LED3, LED4, dbg_state, dbg_mode
  );

  modport slave (
    input  mode, pattern, mode_we,
    output tick, LED0, LED1, LED2, LED3, LED4, dbg_state, dbg_mode
  );
endinterface

// File: rtl/led_pattern_ctrl_prescaler.sv
// Step-tick prescaler: free-running 0..DIV-1 counter, tick on the terminal count,
// restartable from 0 (restart also masks the tick of that same cycle).
module led_prescaler #(
  parameter int DIV   = 4,
  parameter int DIV_W = $clog2(DIV) + 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic tick
);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("led_prescaler: DIV must be >= 2");
    end
  endgenerate

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == LAST) && !restart;

  // Count and wrap; a restart pulls the count back to 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// 5-LED sequencer: latches mode/pattern on a write strobe and steps OFF, STATIC,
// BLINK or a bouncing chase off the prescaled tick. LED outputs are registered.
module led_pattern_ctrl
  import led_pattern_ctrl_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int DIV_W = $clog2(DIV) + 1
) (
  input  logic               clk,
  input  logic               rstn,
  led_pattern_ctrl_if.slave  bus
);

  logic                tick;
  logic [1:0]          mode_r;
  logic [NUM_LEDS-1:0] pattern_r;
  logic [2:0]          state;
  logic [2:0]          pos;
  logic                phase;
  logic [NUM_LEDS-1:0] leds;

  logic [2:0]          state_n;
  logic [2:0]          pos_n;
  logic                phase_n;
  logic [NUM_LEDS-1:0] pattern_n;
  logic [NUM_LEDS-1:0] leds_n;

  // A write restarts the prescaler so the new mode gets a full step period.
  led_prescaler #(.DIV(DIV), .DIV_W(DIV_W)) u_prescaler (
    .clk     (clk),
    .rstn    (rstn),
    .restart (bus.mode_we),
    .tick    (tick)
  );

  // Next state: a write always wins over a tick; LEDs are derived from the next state
  // so the register holding them updates on the same edge as the FSM.
  always_comb begin
    state_n   = state;
    pos_n     = pos;
    phase_n   = phase;
    pattern_n = pattern_r;
    if (bus.mode_we) begin
      state_n   = mode_entry_state(bus.mode);
      pos_n     = 3'd0;
      phase_n   = 1'b1;
      pattern_n = bus.pattern;
    end else if (tick) begin
      case (state)
        S_BLINK: phase_n = ~phase;
        S_UP: begin
          if (pos == 3'd4) begin
            state_n = S_DOWN;
            pos_n   = 3'd3;
          end else begin
            pos_n   = pos + 3'd1;
          end
        end
        S_DOWN: begin
          if (pos == 3'd0) begin
            state_n = S_UP;
            pos_n   = 3'd1;
          end else begin
            pos_n   = pos - 3'd1;
          end
        end
        default: ;
      endcase
    end

    case (state_n)
      S_STATIC:     leds_n = pattern_n;
      S_BLINK:      leds_n = phase_n ? pattern_n : '0;
      S_UP, S_DOWN: leds_n = pos_onehot(pos_n);
      default:      leds_n = '0;
    endcase
  end

  // Config, FSM and LED registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_r    <= MODE_OFF;
      pattern_r <= '0;
      state     <= S_OFF;
      pos       <= 3'd0;
      phase     <= 1'b1;
      leds      <= '0;
    end else begin
      if (bus.mode_we) begin
        mode_r <= bus.mode;
      end
      pattern_r <= pattern_n;
      state     <= state_n;
      pos       <= pos_n;
      phase     <= phase_n;
      leds      <= leds_n;
    end
  end

  assign bus.tick      = tick;
  assign bus.LED0      = leds[0];
  assign bus.LED1      = leds[1];
  assign bus.LED2      = leds[2];
  assign bus.LED3      = leds[3];
  assign bus.LED4      = leds[4];
  assign bus.dbg_state = state;
  assign bus.dbg_mode  = mode_r;

endmodule
